// File: rtl/pipelined_cond_sum_adder.sv
// Two-stage pipelined conditional-sum adder/subtractor with valid/ready flow control.
// Stage 1 precomputes each BLOCK-wide segment for carry-in 0 and 1; stage 2 selects
// the correct segment results from the resolved segment carries.
module pipelined_cond_sum_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c0,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSEG = WIDTH / BLOCK;

    // Stage 1 registers
    logic                       v1_q, v1_d;
    logic [NSEG-1:0][BLOCK-1:0] sum0_q, sum0_d;
    logic [NSEG-1:0][BLOCK-1:0] sum1_q, sum1_d;
    logic [NSEG-1:0]            co0_q, co0_d;
    logic [NSEG-1:0]            co1_q, co1_d;
    logic                       a_msb_q, a_msb_d;
    logic                       b_msb_q, b_msb_d;

    // Stage 2 registers
    logic                       out_valid_q, out_valid_d;
    logic [WIDTH-1:0]           s_q, s_d;
    logic                       cout_q, cout_d;
    logic                       ovf_q, ovf_d;

    logic                       adv;
    logic [WIDTH-1:0]           s_res;
    logic                       cout_res;
    logic                       ovf_res;

    // Both stages move together whenever the output register is free or being drained
    always_comb begin
        adv      = !out_valid_q || out_ready;
        in_ready = adv;
    end

    // Stage 1: effective operands and per-segment conditional sums
    always_comb begin
        logic [WIDTH-1:0] a_eff;
        logic [WIDTH-1:0] b_eff;
        logic             cin;
        logic [BLOCK:0]   t0;
        logic [BLOCK:0]   t1;

        a_eff   = x;
        b_eff   = sub ? ~y : y;
        cin     = sub ? ~c0 : c0;
        t0      = '0;
        t1      = '0;
        sum0_d  = sum0_q;
        sum1_d  = sum1_q;
        co0_d   = co0_q;
        co1_d   = co1_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        v1_d    = v1_q;

        if (adv) begin
            v1_d    = in_valid;
            a_msb_d = a_eff[WIDTH-1];
            b_msb_d = b_eff[WIDTH-1];
            for (int unsigned i = 0; i < NSEG; i++) begin
                if (i == 0) begin
                    // Segment 0 sees the real carry-in, so both slots carry the same result
                    t0 = {1'b0, a_eff[0 +: BLOCK]} + {1'b0, b_eff[0 +: BLOCK]}
                       + {{BLOCK{1'b0}}, cin};
                    t1 = t0;
                end else begin
                    t0 = {1'b0, a_eff[i*BLOCK +: BLOCK]} + {1'b0, b_eff[i*BLOCK +: BLOCK]};
                    t1 = {1'b0, a_eff[i*BLOCK +: BLOCK]} + {1'b0, b_eff[i*BLOCK +: BLOCK]}
                       + {{BLOCK{1'b0}}, 1'b1};
                end
                sum0_d[i] = t0[BLOCK-1:0];
                co0_d[i]  = t0[BLOCK];
                sum1_d[i] = t1[BLOCK-1:0];
                co1_d[i]  = t1[BLOCK];
            end
        end
    end

    // Stage 2: resolve segment carries by selecting between precomputed results
    always_comb begin
        logic carry;

        carry    = co0_q[0];
        s_res    = '0;
        s_res[0 +: BLOCK] = sum0_q[0];
        for (int unsigned i = 1; i < NSEG; i++) begin
            s_res[i*BLOCK +: BLOCK] = carry ? sum1_q[i] : sum0_q[i];
            carry                   = carry ? co1_q[i]  : co0_q[i];
        end
        cout_res = carry;
        ovf_res  = (a_msb_q == b_msb_q) && (s_res[WIDTH-1] != a_msb_q);

        out_valid_d = adv ? v1_q     : out_valid_q;
        s_d         = adv ? s_res    : s_q;
        cout_d      = adv ? cout_res : cout_q;
        ovf_d       = adv ? ovf_res  : ovf_q;
    end

    // Pipeline registers; reset clears valids and visible outputs, data regs are don't-care
    always_ff @(posedge clk) begin
        sum0_q  <= sum0_d;
        sum1_q  <= sum1_d;
        co0_q   <= co0_d;
        co1_q   <= co1_d;
        a_msb_q <= a_msb_d;
        b_msb_q <= b_msb_d;
        if (rst) begin
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cond_sum_adder.sv
// Scoreboard bench for pipelined_cond_sum_adder: directed cases, backpressure,
// mid-stream reset and randomized traffic checked against an arithmetic model.
module tb_pipelined_cond_sum_adder;

    localparam int unsigned W = 16;
    localparam int unsigned B = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c0;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         cout;
    logic         ovf;

    res_t exp_q[$];
    res_t held;
    bit   held_v = 1'b0;
    bit   rand_ready = 1'b0;
    int   vectors = 0;
    int   fails = 0;
    int   checks = 0;
    int   delivered = 0;

    pipelined_cond_sum_adder #(.WIDTH(W), .BLOCK(B)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .c0(c0), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, signed range test for overflow
    function automatic res_t model(logic [W-1:0] xv, logic [W-1:0] yv, logic cv, logic sv);
        res_t   m;
        longint ux, uy, sx, sy, ci, r, sr;
        longint smax, smin;
        ux   = longint'(xv);
        uy   = longint'(yv);
        sx   = longint'($signed(xv));
        sy   = longint'($signed(yv));
        ci   = longint'(cv);
        smax = (64'sd1 <<< (W - 1)) - 1;
        smin = -(64'sd1 <<< (W - 1));
        if (!sv) begin
            r    = ux + uy + ci;
            sr   = sx + sy + ci;
            m.co = (r >= (64'sd1 <<< W));
        end else begin
            r    = ux - uy - ci;
            sr   = sx - sy - ci;
            m.co = (ux >= uy + ci);
        end
        m.s  = r[W-1:0];
        m.ov = (sr > smax) || (sr < smin);
        return m;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + scoreboard push, evaluated mid-cycle while inputs/outputs are stable
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (held_v) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'({S, cout, ovf}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("result", 64'({S, cout, ovf}), 64'(e));
                    delivered++;
                end
            end
            held_v = out_valid && !out_ready;
            held   = '{s: S, co: cout, ov: ovf};
            if (in_valid && in_ready) begin
                exp_q.push_back(model(x, y, c0, sub));
                vectors++;
            end
        end
    end

    // Random consumer backpressure
    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge
    task automatic send(logic [W-1:0] xv, logic [W-1:0] yv, logic cv, logic sv);
        bit rdy;
        rdy      = 1'b0;
        x        = xv;
        y        = yv;
        c0       = cv;
        sub      = sv;
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
        end
        if (!rdy) chk("send_timeout", 64'(rdy), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic directed(string name, logic [W-1:0] xv, logic [W-1:0] yv, logic cv,
                            logic sv, logic [W-1:0] es, logic ec, logic eo);
        out_ready = 1'b1;
        drain();
        send(xv, yv, cv, sv);
        @(negedge clk);
        chk({name, "_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_S"}, 64'(S), 64'(es));
        chk({name, "_cout"}, 64'(cout), 64'(ec));
        chk({name, "_ovf"}, 64'(ovf), 64'(eo));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        // Reset with junk inputs presented: none of them may emerge
        rst       = 1'b1;
        in_valid  = 1'b1;
        x         = 16'h1234;
        y         = 16'h4321;
        c0        = 1'b1;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_S", 64'(S), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk) chk("rst_no_junk", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Directed arithmetic cases
        directed("add",      16'd12,   16'd5,    1'b0, 1'b0, 16'd17,   1'b0, 1'b0);
        directed("add_cin",  16'd12,   16'd5,    1'b1, 1'b0, 16'd18,   1'b0, 1'b0);
        directed("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("sub",      16'd5,    16'd12,   1'b0, 1'b1, 16'hFFF9, 1'b0, 1'b0);
        directed("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed("sub_bin",  16'd7,    16'd7,    1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        // Backpressure: three back-to-back operands, consumer stalls for four cycles
        out_ready = 1'b1;
        drain();
        d0 = delivered;
        fork
            begin
                send(16'h0101, 16'h0202, 1'b0, 1'b0);
                send(16'hF00F, 16'h0FF1, 1'b1, 1'b0);
                send(16'h1000, 16'h2000, 1'b0, 1'b1);
            end
            begin
                @(posedge clk);
                #1 out_ready = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 64'(delivered - d0), 64'd3);

        // Reset with both stages occupied
        out_ready = 1'b0;
        send(16'h00AA, 16'h0055, 1'b0, 1'b0);
        send(16'h0BBB, 16'h0444, 1'b1, 1'b1);
        @(negedge clk);
        chk("mid_full", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        x        = 16'h5555;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_S", 64'(S), 64'd0);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        repeat (4) @(negedge clk) chk("mid_rst_stale", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Random traffic with random consumer stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
